// File: rtl/mm_pipe_bridge_pkg.sv
// Shared definitions for mm_pipe_bridge: Avalon response codes and the packed
// command width helper used to size the command skid register.
package mm_pipe_bridge_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY      = 2'b00,
    RESP_SLVERR    = 2'b10,
    RESP_DECODEERR = 2'b11
  } resp_e;

  // Width of {read, write, debugaccess, burstcount, byteenable, address, writedata}.
  function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw,
                                            input int unsigned bew, input int unsigned bcw);
    return 3 + aw + dw + bew + bcw;
  endfunction

endpackage

// File: rtl/mm_pipe_bridge_skid.sv
// Generic two-entry valid/ready skid register; the main entry drives the output,
// the skid entry absorbs one transfer while the output stalls.
module mm_pipe_bridge_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             in_fire, main_free;

  assign in_fire   = in_valid_i && rdy_q;
  assign main_free = !main_vld_q || out_ready_i;

  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (main_free) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) main_d = in_data_i;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_d     = in_data_i;
    end
  end

  // Ready is registered from the next skid state; it stays low throughout reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_vld_q <= 1'b0;
      main_q     <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      main_q     <= main_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      rdy_q      <= !skid_vld_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_q;

endmodule

// File: rtl/mm_pipe_bridge.sv
// Avalon-MM pipeline bridge: skid-buffered command path, credit-gated reads,
// registered responses. Define MM_PIPE_BRIDGE_WRITERESP_EN for write responses.
module mm_pipe_bridge
  import mm_pipe_bridge_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH        = 32,
  parameter int unsigned  SYMBOL_WIDTH      = 8,
  parameter int unsigned  ADDR_WIDTH        = 15,
  parameter int unsigned  BURSTCOUNT_WIDTH  = 4,
  parameter int unsigned  MAX_PENDING_BEATS = 16,
  localparam int unsigned BE_WIDTH          = DATA_WIDTH / SYMBOL_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR_WIDTH-1:0]       s0_address,
  input  logic [DATA_WIDTH-1:0]       s0_writedata,
  input  logic [BE_WIDTH-1:0]         s0_byteenable,
  input  logic [BURSTCOUNT_WIDTH-1:0] s0_burstcount,
  input  logic                        s0_read,
  input  logic                        s0_write,
  input  logic                        s0_debugaccess,
  output logic                        s0_waitrequest,
  output logic [DATA_WIDTH-1:0]       s0_readdata,
  output logic                        s0_readdatavalid,
  output logic [ADDR_WIDTH-1:0]       m0_address,
  output logic [DATA_WIDTH-1:0]       m0_writedata,
  output logic [BE_WIDTH-1:0]         m0_byteenable,
  output logic [BURSTCOUNT_WIDTH-1:0] m0_burstcount,
  output logic                        m0_read,
  output logic                        m0_write,
  output logic                        m0_debugaccess,
  input  logic                        m0_waitrequest,
`ifdef MM_PIPE_BRIDGE_WRITERESP_EN
  input  logic                        m0_writeresponsevalid,
  input  logic [1:0]                  m0_response,
  output logic                        s0_writeresponsevalid,
  output logic [1:0]                  s0_response,
`endif
  input  logic [DATA_WIDTH-1:0]       m0_readdata,
  input  logic                        m0_readdatavalid
);

  typedef struct packed {
    logic                        read;
    logic                        write;
    logic                        debugaccess;
    logic [BURSTCOUNT_WIDTH-1:0] burstcount;
    logic [BE_WIDTH-1:0]         byteenable;
    logic [ADDR_WIDTH-1:0]       address;
    logic [DATA_WIDTH-1:0]       writedata;
  } cmd_t;

  localparam int unsigned CMD_W = cmd_width(ADDR_WIDTH, DATA_WIDTH, BE_WIDTH, BURSTCOUNT_WIDTH);
  localparam int unsigned PW    = $clog2(MAX_PENDING_BEATS + 1);
  localparam int unsigned CW    = ((PW > BURSTCOUNT_WIDTH) ? PW : BURSTCOUNT_WIDTH) + 2;

  function automatic cmd_t build_cmd(input logic rd, input logic wr, input logic dbg,
                                     input logic [BURSTCOUNT_WIDTH-1:0] bc,
                                     input logic [BE_WIDTH-1:0] be,
                                     input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [DATA_WIDTH-1:0] data);
    cmd_t c;
    c.read        = rd;
    c.write       = wr;
    c.debugaccess = dbg;
    c.burstcount  = bc;
    c.byteenable  = be;
    c.address     = addr;
    c.writedata   = data;
    return c;
  endfunction

  cmd_t             s0_cmd, head;
  logic [CMD_W-1:0] head_bits;
  logic             head_vld, head_ready, in_ready;

  assign s0_cmd = build_cmd(s0_read, s0_write, s0_debugaccess, s0_burstcount,
                            s0_byteenable, s0_address, s0_writedata);

  mm_pipe_bridge_skid #(.WIDTH(CMD_W)) u_cmd_skid (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .in_valid_i  (s0_read || s0_write),
    .in_ready_o  (in_ready),
    .in_data_i   (s0_cmd),
    .out_valid_o (head_vld),
    .out_ready_i (head_ready),
    .out_data_o  (head_bits)
  );

  assign head           = cmd_t'(head_bits);
  assign s0_waitrequest = !in_ready;

  assign m0_address     = head.address;
  assign m0_writedata   = head.writedata;
  assign m0_byteenable  = head.byteenable;
  assign m0_burstcount  = head.burstcount;
  assign m0_debugaccess = head.debugaccess;

  logic [PW-1:0] pending_q, pending_d;
  logic [CW-1:0] beats, sum, dec;
  logic          is_rd, gated, gate_ok;

  // A gated head is withheld from m0 and from the skid's ready until credits allow;
  // returns are subtracted after the issue is added so the counter floors at zero.
  always_comb begin
    is_rd = head.read && !head.write;
    beats = (head.burstcount == '0) ? CW'(1) : CW'(head.burstcount);
`ifdef MM_PIPE_BRIDGE_WRITERESP_EN
    gated = is_rd || head.write;
    if (head.write) beats = CW'(1);
    dec   = CW'(m0_readdatavalid) + CW'(m0_writeresponsevalid);
`else
    gated = is_rd;
    dec   = CW'(m0_readdatavalid);
`endif
    gate_ok    = !gated || ((CW'(pending_q) + beats) <= CW'(MAX_PENDING_BEATS));
    head_ready = !m0_waitrequest && gate_ok;
    m0_read    = head_vld && is_rd && gate_ok;
    m0_write   = head_vld && head.write && gate_ok;
    sum        = CW'(pending_q) + ((head_vld && gated && head_ready) ? beats : '0);
    pending_d  = (sum > dec) ? PW'(sum - dec) : '0;
  end

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rdata_q   <= m0_readdata;
      rvalid_q  <= m0_readdatavalid;
    end
  end

  assign s0_readdata      = rdata_q;
  assign s0_readdatavalid = rvalid_q;

`ifdef MM_PIPE_BRIDGE_WRITERESP_EN
  logic       wrvalid_q;
  logic [1:0] resp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrvalid_q <= 1'b0;
      resp_q    <= RESP_OKAY;
    end else begin
      wrvalid_q <= m0_writeresponsevalid;
      resp_q    <= m0_response;
    end
  end

  assign s0_writeresponsevalid = wrvalid_q;
  assign s0_response           = resp_q;
`endif

endmodule

// File: tb/tb_mm_pipe_bridge.sv
// Scoreboard bench for mm_pipe_bridge: commands and read data are queued at s0/m0
// entry and compared where they leave the bridge; credit count checked against a model.
`timescale 1ns/1ps
module tb_mm_pipe_bridge;
  import mm_pipe_bridge_pkg::*;

  localparam int unsigned DW = 32, AW = 15, BCW = 4, BEW = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [AW-1:0]  s0_address;
  logic [DW-1:0]  s0_writedata;
  logic [BEW-1:0] s0_byteenable;
  logic [BCW-1:0] s0_burstcount;
  logic           s0_read, s0_write, s0_debugaccess;
  logic           s0_waitrequest;
  logic [DW-1:0]  s0_readdata;
  logic           s0_readdatavalid;
  logic [AW-1:0]  m0_address;
  logic [DW-1:0]  m0_writedata;
  logic [BEW-1:0] m0_byteenable;
  logic [BCW-1:0] m0_burstcount;
  logic           m0_read, m0_write, m0_debugaccess;
  logic           m0_waitrequest;
  logic [DW-1:0]  m0_readdata;
  logic           m0_readdatavalid;
`ifdef MM_PIPE_BRIDGE_WRITERESP_EN
  logic           m0_writeresponsevalid;
  logic [1:0]     m0_response;
  logic           s0_writeresponsevalid;
  logic [1:0]     s0_response;
`endif

  always #5 clk = ~clk;

  mm_pipe_bridge #(
    .DATA_WIDTH(DW), .SYMBOL_WIDTH(8), .ADDR_WIDTH(AW),
    .BURSTCOUNT_WIDTH(BCW), .MAX_PENDING_BEATS(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_address(s0_address), .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_burstcount(s0_burstcount), .s0_read(s0_read), .s0_write(s0_write),
    .s0_debugaccess(s0_debugaccess), .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_burstcount(m0_burstcount), .m0_read(m0_read), .m0_write(m0_write),
    .m0_debugaccess(m0_debugaccess), .m0_waitrequest(m0_waitrequest),
`ifdef MM_PIPE_BRIDGE_WRITERESP_EN
    .m0_writeresponsevalid(m0_writeresponsevalid), .m0_response(m0_response),
    .s0_writeresponsevalid(s0_writeresponsevalid), .s0_response(s0_response),
`endif
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid)
  );

  typedef struct packed {
    logic           rd;
    logic           wr;
    logic           dbg;
    logic [BCW-1:0] bc;
    logic [BEW-1:0] be;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
  } cmd_s;

  cmd_s          cmd_q[$];
  logic [DW-1:0] rsp_q[$];
  int unsigned   n_vec = 0, n_err = 0;
  int unsigned   model_pend = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor samples mid-cycle, i.e. the handshake values about to be clocked.
  always @(negedge clk) begin
    if (!reset_n) begin
      cmd_q.delete();
      rsp_q.delete();
      model_pend = 0;
    end else begin
      cmd_s        got, exp;
      int unsigned nxt, bt;
      nxt = model_pend;
      if ((s0_read || s0_write) && !s0_waitrequest)
        cmd_q.push_back('{s0_read, s0_write, s0_debugaccess, s0_burstcount,
                          s0_byteenable, s0_address, s0_writedata});
      if ((m0_read || m0_write) && !m0_waitrequest) begin
        got = '{m0_read, m0_write, m0_debugaccess, m0_burstcount,
                m0_byteenable, m0_address, m0_writedata};
        if (cmd_q.size() == 0) check_val("m0_extra_cmd", 64'(cmd_q.size()), 64'd1);
        else begin
          exp = cmd_q.pop_front();
          check_val("m0_cmd", 64'(got), 64'(exp));
          bt = (exp.bc == 0) ? 1 : int'(exp.bc);
          if (exp.rd) begin
            check_val("credit_bound", 64'(model_pend + bt <= 16), 64'd1);
            nxt += bt;
          end
`ifdef MM_PIPE_BRIDGE_WRITERESP_EN
          if (exp.wr) nxt += 1;
`endif
        end
      end
      if (s0_readdatavalid) begin
        if (rsp_q.size() == 0) check_val("rsp_extra", 64'(rsp_q.size()), 64'd1);
        else check_val("s0_readdata", 64'(s0_readdata), 64'(rsp_q.pop_front()));
      end
      if (m0_readdatavalid) begin
        rsp_q.push_back(m0_readdata);
        if (nxt > 0) nxt--;
      end
`ifdef MM_PIPE_BRIDGE_WRITERESP_EN
      if (m0_writeresponsevalid && nxt > 0) nxt--;
`endif
      model_pend = nxt;
    end
  end

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_cmd(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BEW-1:0] be,
                          input logic [BCW-1:0] bc);
    logic        acc;
    int unsigned n;
    acc = 1'b0;
    n   = 0;
    s0_read = rd; s0_write = wr; s0_address = a; s0_writedata = d;
    s0_byteenable = be; s0_burstcount = bc; s0_debugaccess = a[0];
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = !s0_waitrequest;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_val("host_accept_timeout", 64'(acc), 64'd1);
    s0_read  = 1'b0;
    s0_write = 1'b0;
  endtask

  task automatic ret_beats(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      m0_readdatavalid = 1'b1;
      m0_readdata      = $urandom;
      tick();
    end
    m0_readdatavalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    s0_address = '0; s0_writedata = '0; s0_byteenable = '0; s0_burstcount = '0;
    s0_read = 1'b0; s0_write = 1'b0; s0_debugaccess = 1'b0;
    m0_waitrequest = 1'b0; m0_readdata = '0; m0_readdatavalid = 1'b0;
`ifdef MM_PIPE_BRIDGE_WRITERESP_EN
    m0_writeresponsevalid = 1'b0; m0_response = '0;
`endif

    // Power-on reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_waitreq", 64'(s0_waitrequest), 64'd1);
    check_val("rst_m0_read", 64'(m0_read), 64'd0);
    check_val("rst_m0_write", 64'(m0_write), 64'd0);
    check_val("rst_m0_addr", 64'(m0_address), 64'd0);
    check_val("rst_s0_rdv", 64'(s0_readdatavalid), 64'd0);
    check_val("rst_s0_rdata", 64'(s0_readdata), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    check_val("post_rst_waitreq", 64'(s0_waitrequest), 64'd0);
    check_val("post_rst_pend", 64'(dut.pending_q), 64'd0);

    // Eight back-to-back writes
    fork
      for (int unsigned i = 0; i < 8; i++)
        host_cmd(1'b0, 1'b1, 15'h100 + 15'(i), $urandom, 4'(i + 1), 4'd1);
      for (int unsigned k = 0; k < 10; k++) begin
        @(negedge clk);
        check_val("stream_m0_write", 64'(m0_write), 64'(k >= 1 && k <= 8));
      end
    join
    @(posedge clk); #1;

    // Three cycles of m0 backpressure during four writes
    m0_waitrequest = 1'b1;
    fork
      for (int unsigned i = 0; i < 4; i++)
        host_cmd(1'b0, 1'b1, 15'h200 + 15'(i), $urandom, 4'hf, 4'd1);
      begin
        @(negedge clk);
        check_val("bp_waitreq_c0", 64'(s0_waitrequest), 64'd0);
        @(negedge clk);
        check_val("bp_waitreq_c1", 64'(s0_waitrequest), 64'd0);
        check_val("bp_hold_write_c1", 64'(m0_write), 64'd1);
        check_val("bp_hold_addr_c1", 64'(m0_address), 64'h200);
        @(negedge clk);
        check_val("bp_waitreq_c2", 64'(s0_waitrequest), 64'd1);
        check_val("bp_hold_addr_c2", 64'(m0_address), 64'h200);
        @(posedge clk); #1;
        m0_waitrequest = 1'b0;
      end
    join
    tick(6);
    check_val("bp_drain", 64'(cmd_q.size()), 64'd0);

    // Credit limit: 8 + 8 fill the window, third burst of 8 must wait
    host_cmd(1'b1, 1'b0, 15'h300, '0, 4'hf, 4'd8);
    host_cmd(1'b1, 1'b0, 15'h308, '0, 4'hf, 4'd8);
    host_cmd(1'b1, 1'b0, 15'h310, '0, 4'hf, 4'd8);
    tick(3);
    @(negedge clk);
    check_val("credit_block_read", 64'(m0_read), 64'd0);
    check_val("credit_pend16", 64'(dut.pending_q), 64'd16);
    check_val("credit_pend_model", 64'(dut.pending_q), 64'(model_pend));
    @(posedge clk); #1;
    ret_beats(7);
    @(negedge clk);
    check_val("credit_block_after7", 64'(m0_read), 64'd0);
    @(posedge clk); #1;
    ret_beats(1);
    @(negedge clk);
    check_val("credit_issue_after8", 64'(m0_read), 64'd1);
    @(posedge clk); #1;
    ret_beats(16);
    tick(2);
    check_val("credit_drain_pend", 64'(dut.pending_q), 64'd0);

    // Same-cycle issue and return at pending=15
    host_cmd(1'b1, 1'b0, 15'h400, '0, 4'hf, 4'd8);
    host_cmd(1'b1, 1'b0, 15'h408, '0, 4'hf, 4'd7);
    tick(2);
    check_val("sc_pend15", 64'(dut.pending_q), 64'd15);
    host_cmd(1'b1, 1'b0, 15'h40f, '0, 4'h3, 4'd1);
    m0_readdatavalid = 1'b1;
    m0_readdata      = $urandom;
    @(negedge clk);
    check_val("sc_issue", 64'(m0_read), 64'd1);
    @(posedge clk); #1;
    m0_readdatavalid = 1'b0;
    check_val("sc_pend_same", 64'(dut.pending_q), 64'd15);
    ret_beats(15);
    tick(2);
    check_val("sc_drain_pend", 64'(dut.pending_q), 64'd0);

    // Zero burstcount counts as one beat
    host_cmd(1'b1, 1'b0, 15'h480, '0, 4'hf, 4'd0);
    tick(2);
    check_val("bc0_pend", 64'(dut.pending_q), 64'd1);
    ret_beats(1);
    tick(2);

    // Reset in the middle of traffic with pending=5
    host_cmd(1'b1, 1'b0, 15'h500, '0, 4'hf, 4'd5);
    tick(2);
    check_val("mid_pend5", 64'(dut.pending_q), 64'd5);
    m0_waitrequest = 1'b1;
    host_cmd(1'b0, 1'b1, 15'h510, $urandom, 4'hf, 4'd1);
    host_cmd(1'b0, 1'b1, 15'h511, $urandom, 4'hf, 4'd1);
    reset_n          = 1'b0;
    m0_readdatavalid = 1'b1;
    m0_readdata      = 32'hdead_beef;
    @(posedge clk);
    @(negedge clk);
    check_val("mid_rst_waitreq", 64'(s0_waitrequest), 64'd1);
    check_val("mid_rst_m0_write", 64'(m0_write), 64'd0);
    check_val("mid_rst_m0_read", 64'(m0_read), 64'd0);
    check_val("mid_rst_m0_addr", 64'(m0_address), 64'd0);
    check_val("mid_rst_m0_bc", 64'(m0_burstcount), 64'd0);
    check_val("mid_rst_s0_rdv", 64'(s0_readdatavalid), 64'd0);
    @(posedge clk); #1;
    m0_readdatavalid = 1'b0;
    m0_waitrequest   = 1'b0;
    reset_n          = 1'b1;
    tick();
    check_val("mid_post_waitreq", 64'(s0_waitrequest), 64'd0);
    check_val("mid_post_pend", 64'(dut.pending_q), 64'd0);
    ret_beats(2);
    tick(2);
    check_val("stray_pend", 64'(dut.pending_q), 64'd0);
    check_val("stray_rsp_drain", 64'(rsp_q.size()), 64'd0);

`ifdef MM_PIPE_BRIDGE_WRITERESP_EN
    // Write response with SLVERR returns its credit
    host_cmd(1'b0, 1'b1, 15'h600, $urandom, 4'hf, 4'd1);
    tick(2);
    check_val("wr_credit_taken", 64'(dut.pending_q), 64'd1);
    m0_writeresponsevalid = 1'b1;
    m0_response           = RESP_SLVERR;
    tick();
    m0_writeresponsevalid = 1'b0;
    m0_response           = RESP_OKAY;
    @(negedge clk);
    check_val("wr_resp_valid", 64'(s0_writeresponsevalid), 64'd1);
    check_val("wr_resp_code", 64'(s0_response), 64'h2);
    check_val("wr_credit_back", 64'(dut.pending_q), 64'd0);
    @(posedge clk); #1;
`endif

    tick(4);
    check_val("final_cmd_drain", 64'(cmd_q.size()), 64'd0);
    check_val("final_rsp_drain", 64'(rsp_q.size()), 64'd0);
    check_val("final_pend_model", 64'(dut.pending_q), 64'(model_pend));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
